// File: rtl/mips_pkg.sv
// Shared fetch-front-end types and widths.
// Address/data widths, reset PC default and the fetch-queue FSM state enum.
package mips_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int IFQ_DEPTH = 4;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;

    typedef enum logic [1:0] {
        FETCH,
        STALL,
        FLUSH
    } ifq_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer holding fetched {instruction, pc} entries.
// Flush empties the buffer and wins over a same-cycle push/pop.
module ifq_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign dout = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order fetch front end: issues credited fetches, buffers returned words with their PCs.
// Optional IFQ_BYPASS_EN macro forwards a response straight to decode when the queue is empty.
module instr_fetch_queue
    import mips_pkg::*;
#(
    parameter int                DEPTH    = IFQ_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instrn,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = DATA_W + ADDR_W;
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] redirect_base;
    logic [ADDR_W-1:0] out_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_n;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     drop_cnt_n;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic [CW:0]       credit_used;
    logic [CW:0]       credit_n;
    logic [EW-1:0]     head;
    logic              req_fire;
    logic              rsp_ok;
    logic              rsp_keep;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              head_valid;
    ifq_state_t        state;
    ifq_state_t        state_n;

    assign redirect_base = redirect_pc & ~ADDR_W'(3);
    assign credit_used   = {1'b0, outstanding} + {1'b0, count};

    assign imem_req_valid = !rst && !redirect_valid && (credit_used < FULL);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a memory protocol error and is ignored.
    assign rsp_ok     = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep   = rsp_ok && (drop_cnt == '0);
    assign head_valid = (count != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_keep && !head_valid && if_ready && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = rsp_keep && !redirect_valid && !bypass;
    assign pop  = head_valid && if_ready;

    assign if_valid    = head_valid || bypass;
    assign out_pc      = bypass ? rsp_pc : head[ADDR_W-1:0];
    assign if_pc       = if_valid ? out_pc : '0;
    assign if_pc_plus4 = if_valid ? out_pc + ADDR_W'(4) : '0;
    assign if_instrn   = !if_valid ? '0 :
                         bypass    ? imem_rsp_data : head[EW-1:ADDR_W];

    assign outstanding_n = outstanding + CW'(req_fire) - CW'(rsp_ok);

    ifq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({imem_rsp_data, rsp_pc}),
        .dout  (head),
        .count (count)
    );

    // Next drop/occupancy counts and FSM transition.
    // On redirect every word still in flight is stale, including any already marked for drop.
    always_comb begin
        count_n    = count;
        drop_cnt_n = drop_cnt;
        state_n    = state;
        if (redirect_valid) begin
            count_n    = '0;
            drop_cnt_n = outstanding - CW'(rsp_ok);
        end else begin
            count_n = count + CW'(push) - CW'(pop);
            if (rsp_ok && drop_cnt != '0) drop_cnt_n = drop_cnt - CW'(1);
        end
        credit_n = {1'b0, outstanding_n} + {1'b0, count_n};
        unique case (state)
            FETCH, STALL: begin
                if (drop_cnt_n != '0)    state_n = FLUSH;
                else if (credit_n >= FULL) state_n = STALL;
                else                     state_n = FETCH;
            end
            FLUSH: begin
                if (drop_cnt_n != '0)    state_n = FLUSH;
                else if (credit_n >= FULL) state_n = STALL;
                else                     state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // PC registers, credit and drop counters, FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            state       <= FETCH;
        end else begin
            outstanding <= outstanding_n;
            drop_cnt    <= drop_cnt_n;
            state       <= state_n;
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
                if (rsp_keep) rsp_pc   <= rsp_pc + ADDR_W'(4);
            end
        end
    end

`ifndef SYNTHESIS
    // Responses must correspond to an accepted request.
    assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && outstanding == '0));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a latency-2 memory model and a PC scoreboard.
// Expected PCs are queued as requests are accepted and popped as decode consumes.
module tb_instr_fetch_queue;
    import mips_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instrn;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instrn      (if_instrn),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = '0;
    logic        mem_ready = 1'b0;
    logic        mem_hold = 1'b0;
    int          cyc = 0;
    int          reqs = 0;
    int          pops = 0;
    int          wrap_pops = 0;
    int          first_rsp = -1;
    int          first_pop = -1;

    always @(negedge clk) begin
        logic [31:0] e;
        #1;
        cyc++;
        if (rst) begin
            pend.delete();
            exp_q.delete();
            model_pc       = RESET_PC_DEF;
            reqs           = 0;
            pops           = 0;
            wrap_pops      = 0;
            first_rsp      = -1;
            first_pop      = -1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_req_ready = 1'b0;
        end else begin
            imem_req_ready = mem_ready;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (!mem_hold && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
                if (first_rsp < 0) first_rsp = cyc;
            end
            #1;
            if (if_valid && if_ready) begin
                if (first_pop < 0) first_pop = cyc;
                pops++;
                chk("sb_nonempty_at_pop", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e);
                    chk("if_pc_plus4", if_pc_plus4, e + 32'd4);
                    chk("if_instrn", if_instrn, mem_word(e));
                    if (e == 32'hFFFF_FFFC) wrap_pops++;
                end
            end
            if (redirect_valid) begin
                chk("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
                exp_q.delete();
                model_pc = redirect_pc & ~32'd3;
            end else if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, model_pc);
                pend.push_back('{addr: imem_req_addr, due: cyc + LAT});
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                reqs++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        mem_ready      = 1'b0;
        mem_hold       = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int snap;

        // 1: reset state, then free-running fetch with 2-cycle memory
        step(2);
        #3;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instrn", if_instrn, 32'd0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        chk("rst_state", 32'(dut.state), 32'(FETCH));
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b1;
        if_ready  = 1'b1;
        step(20);
        chk("t1_pops", 32'(pops >= 8), 32'd1);
`ifdef IFQ_BYPASS_EN
        chk("t1_latency", 32'(first_pop - first_rsp), 32'd0);
`else
        chk("t1_latency", 32'(first_pop - first_rsp), 32'd1);
`endif

        // 2: decode stalled, credits exhaust at DEPTH
        do_reset();
        mem_ready = 1'b1;
        if_ready  = 1'b0;
        step(12);
        #2;
        chk("t2_reqs", 32'(reqs), 32'd4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_state", 32'(dut.state), 32'(STALL));
        chk("t2_count", 32'(dut.count), 32'd4);
        @(negedge clk);
        if_ready = 1'b1;
        step(1);
        if_ready = 1'b0;
        step(8);
        #2;
        chk("t2_one_pop", 32'(pops), 32'd1);
        chk("t2_reqs_after_pop", 32'(reqs), 32'd5);
        chk("t2_count_refill", 32'(dut.count), 32'd4);
        chk("t2_req_valid_after", 32'(imem_req_valid), 32'd0);

        // 3: redirect with 3 fetches in flight
        do_reset();
        mem_hold  = 1'b1;
        mem_ready = 1'b1;
        step(3);
        mem_ready = 1'b0;
        step(1);
        chk("t3_reqs", 32'(reqs), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step(1);
        redirect_valid = 1'b0;
        #2;
        chk("t3_state_flush", 32'(dut.state), 32'(FLUSH));
        chk("t3_drop_cnt", 32'(dut.drop_cnt), 32'd3);
        chk("t3_if_valid", 32'(if_valid), 32'd0);
        snap      = pops;
        mem_hold  = 1'b0;
        mem_ready = 1'b1;
        if_ready  = 1'b1;
        step(20);
        #2;
        chk("t3_drop_done", 32'(dut.drop_cnt), 32'd0);
        chk("t3_state_fetch", 32'(dut.state), 32'(FETCH));
        chk("t3_pops", 32'(pops - snap >= 5), 32'd1);

        // 4: redirect coinciding with a response and a pop, 2 outstanding
        do_reset();
        mem_hold  = 1'b1;
        mem_ready = 1'b1;
        step(3);
        mem_ready = 1'b0;
        step(1);
        mem_hold = 1'b0;
        step(1);
        mem_hold = 1'b1;
        step(1);
        #2;
        chk("t4_pre_count", 32'(dut.count), 32'd1);
        chk("t4_pre_outstanding", 32'(dut.outstanding), 32'd2);
        @(negedge clk);
        mem_hold       = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step(1);
        mem_hold       = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        #2;
        chk("t4_drop_cnt", 32'(dut.drop_cnt), 32'd1);
        chk("t4_count", 32'(dut.count), 32'd0);
        chk("t4_pop_counted", 32'(pops), 32'd1);
        snap      = pops;
        mem_hold  = 1'b0;
        mem_ready = 1'b1;
        if_ready  = 1'b1;
        step(15);
        chk("t4_pops", 32'(pops - snap >= 3), 32'd1);

        // 5: fetch PC wraps past the top of the address space
        do_reset();
        mem_ready      = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step(1);
        redirect_valid = 1'b0;
        step(15);
        chk("t5_wrap_entry", 32'(wrap_pops), 32'd1);
        chk("t5_pops", 32'(pops >= 6), 32'd1);

        // 6: reset asserted while flushing
        do_reset();
        mem_hold  = 1'b1;
        mem_ready = 1'b1;
        step(3);
        mem_ready = 1'b0;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step(1);
        redirect_valid = 1'b0;
        #2;
        chk("t6_pre_state", 32'(dut.state), 32'(FLUSH));
        chk("t6_pre_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #3;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_if_valid", 32'(if_valid), 32'd0);
        chk("t6_if_pc", if_pc, 32'd0);
        chk("t6_if_instrn", if_instrn, 32'd0);
        chk("t6_if_pc_plus4", if_pc_plus4, 32'd0);
        chk("t6_state", 32'(dut.state), 32'(FETCH));
        chk("t6_drop_cnt", 32'(dut.drop_cnt), 32'd0);
        step(2);
        rst       = 1'b0;
        mem_hold  = 1'b0;
        mem_ready = 1'b1;
        if_ready  = 1'b1;
        step(12);
        chk("t6_pops", 32'(pops >= 4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
